// File: rtl/prg_bus_bridge.sv
// NES cart PRG bus to SDRAM channel-1 bridge: synchronizes the asynchronous CPU
// bus, decodes PRG-ROM/PRG-RAM cycles and issues one word request per cycle.
module prg_bus_bridge #(
  parameter int          ADDR_BITS = 22,
  parameter int unsigned PRG_BASE  = 0,
  parameter int unsigned RAM_BASE  = 'h100000,
  parameter int          SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m2,
  input  logic                 romsel,
  input  logic                 cpu_rw,
  input  logic [14:0]          cpu_addr,
  input  logic [7:0]           cpu_data_in,
  output logic [7:0]           cpu_data_out,
  output logic                 cpu_data_oe,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [15:0]          mem_wdata,
  output logic [1:0]           mem_wmask,
  input  logic                 mem_ack,
  input  logic [15:0]          mem_rdata
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, SETTLE_W, RD_REQ, RD_DRIVE, WR_WAIT, WR_REQ, DRAIN
  } state_t;

  state_t state_q, state_d;

  logic        m2_q1, m2_s, m2_d;
  logic        romsel_q1, romsel_s, romsel_d;
  logic        rw_q1, rw_s;
  logic [14:0] addr_q1, addr_s;
  logic [7:0]  data_q1, data_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      m2_q1     <= 1'b0;
      m2_s      <= 1'b0;
      m2_d      <= 1'b0;
      romsel_q1 <= 1'b0;
      romsel_s  <= 1'b0;
      romsel_d  <= 1'b0;
      rw_q1     <= 1'b0;
      rw_s      <= 1'b0;
      addr_q1   <= '0;
      addr_s    <= '0;
      data_q1   <= '0;
      data_s    <= '0;
    end else begin
      m2_q1     <= m2;
      m2_s      <= m2_q1;
      m2_d      <= m2_s;
      romsel_q1 <= romsel;
      romsel_s  <= romsel_q1;
      romsel_d  <= romsel_s;
      rw_q1     <= cpu_rw;
      rw_s      <= rw_q1;
      addr_q1   <= cpu_addr;
      addr_s    <= addr_q1;
      data_q1   <= cpu_data_in;
      data_s    <= data_q1;
    end
  end

  logic m2_rise, m2_fall, romsel_rise;
  assign m2_rise     = m2_s & ~m2_d;
  assign m2_fall     = ~m2_s & m2_d;
  assign romsel_rise = romsel_s & ~romsel_d;

  logic                 dec_rom, dec_ram;
  logic [ADDR_BITS-1:0] rom_addr, ram_addr, dec_addr;
  assign dec_rom  = ~romsel_s & rw_s;
  assign dec_ram  = romsel_s & (addr_s[14:13] == 2'b11);
  assign rom_addr = ADDR_BITS'(PRG_BASE) + ADDR_BITS'(addr_s[14:1]);
  assign ram_addr = ADDR_BITS'(RAM_BASE) + ADDR_BITS'(addr_s[12:1]);
  assign dec_addr = dec_rom ? rom_addr : ram_addr;

  logic [CW-1:0] cnt_q;
  logic          is_rom_q, pending_q, pending_d;
  logic          cnt_load, load_dec, load_wdata, load_rdata;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    cnt_load   = 1'b0;
    load_dec   = 1'b0;
    load_wdata = 1'b0;
    load_rdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (m2_rise) begin
          state_d  = SETTLE_W;
          cnt_load = 1'b1;
        end
      end
      SETTLE_W: begin
        if (cnt_q != '0) begin
          if (m2_fall) state_d = IDLE;
        end else if (dec_rom || (dec_ram && rw_s)) begin
          load_dec = 1'b1;
          state_d  = m2_fall ? IDLE : RD_REQ;
        end else if (dec_ram) begin
          // A write whose M2 already fell still carries valid data this cycle.
          load_dec = 1'b1;
          if (m2_fall) begin
            load_wdata = 1'b1;
            state_d    = WR_REQ;
          end else begin
            state_d = WR_WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          load_rdata = 1'b1;
          state_d    = m2_fall ? IDLE : RD_DRIVE;
        end else if (m2_fall) begin
          state_d = DRAIN;
        end
      end
      RD_DRIVE: begin
        if (m2_fall || (is_rom_q && romsel_rise)) state_d = IDLE;
      end
      WR_WAIT: begin
        if (m2_fall) begin
          load_wdata = 1'b1;
          state_d    = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem_ack) state_d = IDLE;
      end
      DRAIN: begin
        // The CPU cycle is gone; finish the request and drop its data.
        if (m2_rise) pending_d = 1'b1;
        if (mem_ack) begin
          pending_d = 1'b0;
          if (pending_q || m2_rise) begin
            state_d  = SETTLE_W;
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      is_rom_q     <= 1'b0;
      pending_q    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
      cpu_data_out <= '0;
    end else begin
      pending_q <= pending_d;
      if (cnt_load)                                cnt_q <= CW'(SETTLE);
      else if (state_q == SETTLE_W && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      if (load_dec) begin
        is_rom_q  <= dec_rom;
        mem_addr  <= dec_addr;
        mem_wmask <= addr_s[0] ? 2'b10 : 2'b01;
      end
      if (load_wdata) mem_wdata <= {data_s, data_s};
      if (load_rdata) cpu_data_out <= mem_wmask[1] ? mem_rdata[15:8] : mem_rdata[7:0];
    end
  end

  // Request handshake: mem_req rises with every request field already valid,
  // fields hold while mem_req=1, and mem_req falls the cycle after the mem_ack pulse.
  assign mem_req     = (state_q == RD_REQ) || (state_q == WR_REQ) || (state_q == DRAIN);
  assign mem_we      = (state_q == WR_REQ);
  assign cpu_data_oe = (state_q == RD_DRIVE);

endmodule

// File: tb/tb_prg_bus_bridge.sv
// Bench for prg_bus_bridge: vector table of CPU cycles, an SDRAM responder with a
// request scoreboard, and hand-written sequences for drain and reset corners.
module tb_prg_bus_bridge;
  localparam int ADDR_BITS = 22;
  localparam int RW        = 1 + ADDR_BITS + 16 + 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 m2, romsel, cpu_rw;
  logic [14:0]          cpu_addr;
  logic [7:0]           cpu_data_in;
  logic [7:0]           cpu_data_out;
  logic                 cpu_data_oe;
  logic                 mem_req, mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [15:0]          mem_wdata;
  logic [1:0]           mem_wmask;
  logic                 mem_ack;
  logic [15:0]          mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0] exp_req_q[$];
  logic [7:0]    exp_byte_q[$];
  int            req_cnt   = 0;
  int            oe_cnt    = 0;
  int            ack_delay = 1;
  logic          auto_ack  = 1'b1;
  logic          force_ack = 1'b0;
  logic [15:0]   rdata_val = 16'h0;

  always #5 clk = ~clk;

  prg_bus_bridge #(.ADDR_BITS(ADDR_BITS), .PRG_BASE(0), .RAM_BASE('h100000), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .m2(m2), .romsel(romsel), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .cpu_data_oe(cpu_data_oe), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM responder and request scoreboard.
  initial begin
    logic          req_seen = 1'b0;
    logic          ack_sent = 1'b0;
    logic [RW-1:0] cur, hold, e;
    int            cnt = 0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    hold      = '0;
    forever begin
      @(negedge clk);
      if (auto_ack) mem_ack = 1'b0;
      else          mem_ack = force_ack;
      if (reset) begin
        req_seen = 1'b0;
        ack_sent = 1'b0;
        continue;
      end
      if (ack_sent) begin
        check("req_drop_after_ack", mem_req, 0);
        ack_sent = 1'b0;
      end
      if (mem_req) begin
        cur = {mem_we, mem_addr, mem_wdata, mem_wmask};
        if (!req_seen) begin
          req_seen = 1'b1;
          req_cnt++;
          cnt  = ack_delay;
          hold = cur;
          total++;
          if (exp_req_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_req: got addr %0h we %0b expected no request", mem_addr, mem_we);
          end else begin
            total--;
            e = exp_req_q.pop_front();
            check("req_we", mem_we, e[RW-1]);
            check("req_addr", mem_addr, e[RW-2 -: ADDR_BITS]);
            if (e[RW-1]) begin
              check("req_wdata", mem_wdata, e[17:2]);
              check("req_wmask", mem_wmask, e[1:0]);
            end
          end
        end else begin
          check("req_stable", cur, hold);
        end
        if (auto_ack) begin
          if (cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata_val;
            req_seen  = 1'b0;
            ack_sent  = 1'b1;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Read-byte scoreboard: one expected byte per output-enable window.
  initial begin
    logic oe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_data_oe && !oe_prev) begin
        oe_cnt++;
        total++;
        if (exp_byte_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_oe: got oe=1 data %0h expected oe=0", cpu_data_out);
        end else begin
          total--;
          check("rd_byte", cpu_data_out, exp_byte_q.pop_front());
        end
      end
      oe_prev = cpu_data_oe;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cpu_cycle(input logic [14:0] a, input logic rs, input logic rw,
                           input logic [7:0] d, input int high);
    @(negedge clk);
    cpu_addr    = a;
    cpu_rw      = rw;
    cpu_data_in = d;
    romsel      = rs;
    m2          = 1'b1;
    repeat (high) @(negedge clk);
    m2     = 1'b0;
    romsel = 1'b1;
    repeat (10) @(negedge clk);
    cpu_rw = 1'b1;
  endtask

  typedef struct {
    logic [14:0]   addr;
    logic          rs;
    logic          rw;
    logic [7:0]    din;
    logic [15:0]   rdata;
    logic          exp_req;
    logic [RW-1:0] exp_rec;
    logic          exp_oe;
    logic [7:0]    exp_byte;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int r0, o0, lat;
    logic [14:0] ra;
    logic [15:0] rd;

    vecs[0] = '{15'h0010, 1'b0, 1'b0, 8'h77, 16'h0000, 1'b0, '0, 1'b0, 8'h00};
    vecs[1] = '{15'h4016, 1'b1, 1'b1, 8'h00, 16'h0000, 1'b0, '0, 1'b0, 8'h00};
    vecs[2] = '{15'h6003, 1'b1, 1'b0, 8'h5A, 16'h0000, 1'b1, {1'b1, 22'h100001, 16'h5A5A, 2'b10}, 1'b0, 8'h00};
    vecs[3] = '{15'h7FFE, 1'b0, 1'b1, 8'h00, 16'h1234, 1'b1, {1'b0, 22'h003FFF, 16'h0000, 2'b00}, 1'b1, 8'h34};
    vecs[4] = '{15'h7FFF, 1'b0, 1'b1, 8'h00, 16'h1234, 1'b1, {1'b0, 22'h003FFF, 16'h0000, 2'b00}, 1'b1, 8'h12};
    vecs[5] = '{15'h7FFF, 1'b1, 1'b1, 8'h00, 16'hABCD, 1'b1, {1'b0, 22'h100FFF, 16'h0000, 2'b00}, 1'b1, 8'hAB};
    vecs[6] = '{15'h6000, 1'b1, 1'b0, 8'hC3, 16'h0000, 1'b1, {1'b1, 22'h100000, 16'hC3C3, 2'b01}, 1'b0, 8'h00};
    vecs[7] = '{15'h0000, 1'b0, 1'b1, 8'h00, 16'h55AA, 1'b1, {1'b0, 22'h000000, 16'h0000, 2'b00}, 1'b1, 8'hAA};
    vecs[8] = '{15'h4010, 1'b1, 1'b0, 8'h99, 16'h0000, 1'b0, '0, 1'b0, 8'h00};

    // clock/reset
    reset = 1'b1; m2 = 1'b0; romsel = 1'b1; cpu_rw = 1'b1;
    cpu_addr = '0; cpu_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_cpu_data_out", cpu_data_out, 0);
    check("rst_cpu_data_oe", cpu_data_oe, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // ROM read at $8005: latency, drive window and release after M2 fall
    rdata_val = 16'hBEEF;
    ack_delay = 1;
    exp_req_q.push_back({1'b0, 22'h000002, 16'h0000, 2'b00});
    exp_byte_q.push_back(8'hBE);
    @(negedge clk);
    cpu_addr = 15'h0005; romsel = 1'b0; cpu_rw = 1'b1; m2 = 1'b1;
    lat = 0;
    while (!mem_req && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rom_req_latency_ok", (lat <= 6) && mem_req, 1);
    lat = 0;
    while (!cpu_data_oe && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rom_oe_on", cpu_data_oe, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rom_oe_hold", cpu_data_oe, 1);
    check("rom_data_out", cpu_data_out, 8'hBE);
    @(negedge clk);
    m2 = 1'b0; romsel = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rom_oe_off", cpu_data_oe, 0);
    repeat (6) @(negedge clk);

    // vector table
    for (int i = 0; i < 9; i++) begin
      rdata_val = vecs[i].rdata;
      ack_delay = $urandom_range(0, 3);
      if (vecs[i].exp_req) exp_req_q.push_back(vecs[i].exp_rec);
      if (vecs[i].exp_oe)  exp_byte_q.push_back(vecs[i].exp_byte);
      r0 = req_cnt;
      o0 = oe_cnt;
      cpu_cycle(vecs[i].addr, vecs[i].rs, vecs[i].rw, vecs[i].din, 16);
      check($sformatf("vec%0d_reqs", i), req_cnt - r0, vecs[i].exp_req);
      check($sformatf("vec%0d_oe", i), oe_cnt - o0, vecs[i].exp_oe);
    end

    // random ROM reads against a small address/lane model
    for (int i = 0; i < 6; i++) begin
      ra = 15'($urandom_range(0, 'h7FFF));
      rd = 16'($urandom);
      rdata_val = rd;
      ack_delay = $urandom_range(0, 3);
      exp_req_q.push_back({1'b0, 8'h00, ra[14:1], 16'h0000, 2'b00});
      exp_byte_q.push_back(ra[0] ? rd[15:8] : rd[7:0]);
      cpu_cycle(ra, 1'b0, 1'b1, 8'h00, 16);
    end

    // slow ack: drain, discard, then a next read started during the drain
    r0 = req_cnt;
    o0 = oe_cnt;
    ack_delay = 25;
    rdata_val = 16'hDEAD;
    exp_req_q.push_back({1'b0, 22'h000008, 16'h0000, 2'b00});
    cpu_cycle(15'h0010, 1'b0, 1'b1, 8'h00, 14);
    ack_delay = 1;
    rdata_val = 16'h4321;
    exp_req_q.push_back({1'b0, 22'h000000, 16'h0000, 2'b00});
    exp_byte_q.push_back(8'h21);
    cpu_cycle(15'h0000, 1'b0, 1'b1, 8'h00, 30);
    check("drain_reqs", req_cnt - r0, 2);
    check("drain_oe", oe_cnt - o0, 1);

    // reset while a request is pending, followed by a stale ack
    auto_ack = 1'b0;
    r0 = req_cnt;
    exp_req_q.push_back({1'b0, 22'h00091A, 16'h0000, 2'b00});
    @(negedge clk);
    cpu_addr = 15'h1234; romsel = 1'b0; cpu_rw = 1'b1; m2 = 1'b1;
    lat = 0;
    while (!mem_req && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rst_mid_req_up", mem_req, 1);
    @(negedge clk);
    reset = 1'b1; m2 = 1'b0; romsel = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_req_low", mem_req, 0);
    check("rst_mid_oe_low", cpu_data_oe, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    force_ack = 1'b1;
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    check("stale_ack_req", mem_req, 0);
    check("stale_ack_oe", cpu_data_oe, 0);
    repeat (4) @(posedge clk);
    #1;
    check("stale_ack_req_later", mem_req, 0);
    check("stale_ack_addr_kept", mem_addr, 0);
    check("stale_ack_reqs", req_cnt - r0, 1);
    auto_ack = 1'b1;
    repeat (4) @(negedge clk);

    check("exp_req_q_empty", exp_req_q.size(), 0);
    check("exp_byte_q_empty", exp_byte_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prg_bus_bridge.md
Name: prg_bus_bridge

Overview:
- Cart-side consumer of SDRAM channel 1: turns asynchronous NES CPU bus cycles into SDRAM word requests.
- Serves PRG-ROM reads ($8000-$FFFF, ROMSEL low) and PRG-RAM reads/writes ($6000-$7FFF).
- Drives the read byte back toward CPU_DATA.
- Sits between the cart pins and the ch1 side of the SDRAM controller. The top level maps its flat request port onto the ch1 bus and its cpu_data_oe onto CPU_DIR and the CPU_DATA tri-state.

Parameters:
- ADDR_BITS, 22, SDRAM word-address width.
- PRG_BASE, 0, SDRAM word address of PRG-ROM byte 0.
- RAM_BASE, 'h100000, SDRAM word address of PRG-RAM byte 0.
- SETTLE, 2, clk cycles waited after synced M2 rise before decoding address/ROMSEL/RW.

Ports:
- clk  in  1  system clock (SDRAM controller clock domain)
- reset  in  1  synchronous, active-high reset
- m2  in  1  NES M2, asynchronous
- romsel  in  1  NES ROMSEL (active low), asynchronous
- cpu_rw  in  1  1 = read, asynchronous
- cpu_addr  in  15  CPU A14..A0, asynchronous
- cpu_data_in  in  8  CPU_DATA pin input, asynchronous
- cpu_data_out  out  8  byte to drive on CPU_DATA
- cpu_data_oe  out  1  1 = drive CPU_DATA (also drives CPU_DIR)
- mem_req  out  1  request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_BITS  SDRAM word address
- mem_wdata  out  16  write data, byte replicated in both halves
- mem_wmask  out  2  byte enables, bit0 = low byte
- mem_ack  in  1  one-cycle pulse on completion; mem_rdata valid in that cycle
- mem_rdata  in  16  read data

Behaviour:
- Sync: m2, romsel, cpu_rw, cpu_addr and cpu_data_in each pass through 2-FF synchronizers. All decoding uses the synced copies. m2 rise/fall are detected from the synced m2 and its delayed copy.
- Decode, taken SETTLE cycles after the synced m2 rise:
  - ROM: romsel=0, rw=1. addr = PRG_BASE + cpu_addr[14:1].
  - RAM: romsel=1, cpu_addr[14:13]=2'b11. addr = RAM_BASE + cpu_addr[12:1].
  - ROM writes are ignored. Anything else: no request.
- Byte lane: cpu_addr[0]=0 selects the low byte, 1 selects the high byte. mem_wmask is 2'b01 or 2'b10 accordingly.
- FSM states: IDLE, SETTLE_W, RD_REQ, RD_DRIVE, WR_WAIT, WR_REQ, DRAIN.
  - IDLE: m2 rise -> SETTLE_W (counter = SETTLE).
  - SETTLE_W: at count 0, decode. ROM/RAM read -> RD_REQ. RAM write -> WR_WAIT. Otherwise -> IDLE. If m2 falls before count 0 -> IDLE.
  - RD_REQ: mem_req=1, mem_we=0. On mem_ack, latch the selected byte into cpu_data_out and go to RD_DRIVE. If m2 falls first -> DRAIN.
  - RD_DRIVE: cpu_data_oe=1. Synced m2 fall or synced romsel rise (ROM cycle) -> clear oe, go to IDLE.
  - WR_WAIT: on m2 fall, capture the synced data byte from the same sync stage as that edge. Set mem_wdata = {byte,byte}, go to WR_REQ.
  - WR_REQ: mem_req=1, mem_we=1 until mem_ack -> IDLE.
  - DRAIN: mem_req held until mem_ack. The read data is discarded, then -> IDLE. An m2 rise during DRAIN is remembered (single flag) and its decode is started on exit.
- Request rules:
  - mem_addr, mem_we, mem_wdata and mem_wmask are stable for the whole time mem_req=1.
  - mem_req drops in the cycle after mem_ack.
  - mem_ack in any state without a request is ignored.
- cpu_data_oe is never 1 outside RD_DRIVE, and never 1 for a write or an undecoded cycle.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, cpu_data_out=0, cpu_data_oe=0, FSM=IDLE, sync FFs=0.
- Reset mid-operation: outputs return to reset values next cycle. An ack arriving later is ignored.
- Latency: m2 pin rise to mem_req is at most 2+1+SETTLE+1 clk.

Test Plan:
- ROM read at cpu_addr='h0005, romsel=0, rw=1; mem_rdata='hBEEF on ack -> mem_addr=PRG_BASE+2, cpu_data_out='hBE, oe=1 until m2 falls, then oe=0 within 3 clk.
- RAM write at cpu_addr='h6003, romsel=1, rw=0, data='h5A -> after the m2 fall: mem_we=1, mem_addr=RAM_BASE+'h1, mem_wdata='h5A5A, mem_wmask=2'b10. No oe at any point.
- ROM write at 'h0010 (romsel=0, rw=0), and a read at $4016 (cpu_addr='h4016, romsel=1) -> no mem_req, oe stays 0.
- Slow ack: mem_ack delayed past the m2 fall -> DRAIN, oe never asserted, data discarded. Next ROM read at 'h0000 is serviced normally.
- reset asserted while mem_req=1 -> next cycle mem_req=0, oe=0. A stale ack one cycle later causes no state change.
- Back-to-back ROM reads 'h7FFE then 'h7FFF, with mem_rdata='h1234 on both acks -> cpu_data_out 'h34 then 'h12, both with mem_addr=PRG_BASE+'h3FFF.
